// File: rtl/gray_counter_ctrl_if.sv
// Command channel of gray_counter_ctrl: a valid/ready handshake carrying a
// step count and a "clear first" flag.
interface gray_counter_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_clear;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_clear,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_clear,
        output cmd_ready
    );
endinterface

// File: rtl/gray_counter_ctrl.sv
// Command sequencer for one gray_counter: issues clear/enable strobes, flags wrap.
// Optional Gray integrity checker compiled in with `define GRAY_CTRL_CHECK_EN.
module gray_counter_ctrl #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_counter_ctrl_if.slave   cmd,
    input  logic                 abort,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    input  logic [WIDTH-1:0]     bin_in,
    input  logic [WIDTH-1:0]     gray_in,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_W-1:0]     steps_left,
    output logic                 wrap,
    output logic                 err
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] steps_reg, steps_next;
    logic             aborted_reg, aborted_next;
    logic             ready_comb;

    // Strobes and the sampled counter value from the previous cycle; the
    // counter shows the effect of a strobe one cycle after it is issued.
    logic             en_d_reg;
    logic [WIDTH-1:0] bin_prev_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            steps_reg    <= '0;
            aborted_reg  <= 1'b0;
            en_d_reg     <= 1'b0;
            bin_prev_reg <= '0;
        end else begin
            state_reg    <= state_next;
            steps_reg    <= steps_next;
            aborted_reg  <= aborted_next;
            en_d_reg     <= cnt_en;
            bin_prev_reg <= bin_in;
        end
    end

    always_comb begin
        state_next   = state_reg;
        steps_next   = steps_reg;
        aborted_next = aborted_reg;
        ready_comb   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready_comb = 1'b1;
                if (cmd.cmd_valid) begin
                    steps_next   = cmd.cmd_steps;
                    aborted_next = 1'b0;
                    if (cmd.cmd_clear)
                        state_next = ST_CLEAR;
                    else if (cmd.cmd_steps != '0)
                        state_next = ST_RUN;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                cnt_clr = 1'b1;
                state_next = (steps_reg != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                busy = 1'b1;
                // Abort gates the enable in the same cycle and freezes the count.
                if (abort) begin
                    state_next   = ST_DONE;
                    aborted_next = 1'b1;
                end else begin
                    cnt_en     = 1'b1;
                    steps_next = steps_reg - 1'b1;
                    if (steps_reg == CNT_W'(1))
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cmd.cmd_ready = ready_comb;
    assign aborted       = done & aborted_reg;
    assign steps_left    = steps_reg;
    assign wrap          = en_d_reg & (&bin_prev_reg) & (bin_in == '0);

`ifdef GRAY_CTRL_CHECK_EN
    logic             clr_d_reg;
    logic             prev_valid_reg;
    logic             err_reg;
    logic [WIDTH-1:0] gray_prev_reg;
    logic [WIDTH-1:0] gray_exp;
    logic [WIDTH-1:0] gray_diff;
    logic             violation;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray_exp
        if (gi == WIDTH - 1) begin : g_msb
            assign gray_exp[gi] = bin_in[gi];
        end else begin : g_lsb
            assign gray_exp[gi] = bin_in[gi] ^ bin_in[gi+1];
        end
    end

    assign gray_diff = gray_in ^ gray_prev_reg;

    // Transition rules only apply once a previous sample exists after reset.
    always_comb begin
        violation = (gray_in != gray_exp);
        if (prev_valid_reg) begin
            if (clr_d_reg)
                violation = violation | (gray_in != '0);
            else if (en_d_reg)
                violation = violation |
                            !((gray_diff != '0) && ((gray_diff & (gray_diff - 1'b1)) == '0));
            else
                violation = violation | (gray_diff != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clr_d_reg      <= 1'b0;
            prev_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            gray_prev_reg  <= '0;
        end else begin
            clr_d_reg      <= cnt_clr;
            prev_valid_reg <= 1'b1;
            gray_prev_reg  <= gray_in;
            if (violation)
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    logic gray_unused;
    assign gray_unused = ^gray_in;
    assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Randomized self-checking bench for gray_counter_ctrl driving a behavioural
// gray_counter; expectations come from per-command arithmetic, not the FSM.
module tb_gray_counter_ctrl;
    localparam int W = 3;
    localparam int C = 8;
`ifdef GRAY_CTRL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gray_counter_ctrl_if #(.CNT_W(C)) cmd_bus ();

    logic         abort;
    logic         cnt_clr, cnt_en, busy, done, aborted, wrap, err;
    logic [C-1:0] steps_left;
    logic [W-1:0] bin_in, gray_in;

    gray_counter_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_bus),
        .abort      (abort),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .bin_in     (bin_in),
        .gray_in    (gray_in),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left),
        .wrap       (wrap),
        .err        (err)
    );

    // Behavioural counter attached to the controller, with a Gray override hook.
    logic [W-1:0] cnt        = '0;
    logic         force_gray = 1'b0;
    logic [W-1:0] force_val  = '0;
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign bin_in  = cnt;
    assign gray_in = force_gray ? force_val : (cnt ^ (cnt >> 1));

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_cnt = 0;
    logic [W-1:0] gray_log[$];
    logic         wrap_log[$];

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Issues one command starting in the current (idle) cycle and checks every
    // cycle up to and including the done cycle. ab_at = RUN cycle that aborts.
    task automatic run_cmd(input logic clr, input int n, input int ab_at,
                           input logic keep, input logic noise);
        int off, runlen, enables, done_i, base, wraps_exp, wraps, j, exp_sl;
        logic ab, in_run;
        logic [5:0] exp_v, got_v;
        off       = clr ? 1 : 0;
        ab        = (ab_at > 0) && (ab_at <= n);
        runlen    = ab ? ab_at : n;
        enables   = ab ? ab_at - 1 : n;
        done_i    = off + runlen + 1;
        base      = clr ? 0 : ref_cnt;
        wraps_exp = (base + enables) / (1 << W);
        wraps     = 0;
        gray_log.delete();
        wrap_log.delete();
        for (int i = 0; i <= done_i; i++) begin
            j      = i - off;
            in_run = (j >= 1) && (j <= runlen);
            if (i == 0) begin
                cmd_bus.cmd_valid = 1'b1;
                cmd_bus.cmd_steps = C'(n);
                cmd_bus.cmd_clear = clr;
            end else if (i == 1 && !keep) begin
                cmd_bus.cmd_valid = 1'b0;
            end
            abort = (ab && in_run && j == ab_at) || (noise && (i == 0 || (clr && i == 1)));
            @(negedge clk);
            // {ready, busy, clr, en, done, aborted}
            exp_v = {(i == 0), (i >= 1 && i < done_i), (clr && i == 1),
                     (in_run && !(ab && j == ab_at)), (i == done_i), (i == done_i && ab)};
            got_v = {cmd_bus.cmd_ready, busy, cnt_clr, cnt_en, done, aborted};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL strobes cyc=%0d clr=%0d n=%0d ab=%0d: got %b expected %b",
                         i, clr, n, ab_at, got_v, exp_v);
            end
            if (i >= 1) begin
                if (in_run)           exp_sl = n - (j - 1);
                else if (i == done_i) exp_sl = n - enables;
                else                  exp_sl = n;
                n_cmp++;
                if (steps_left !== C'(exp_sl)) begin
                    n_fail++;
                    $display("FAIL steps_left cyc=%0d: got %0d expected %0d", i, steps_left, exp_sl);
                end
                if (wrap === 1'b1) wraps++;
            end
            if (i == done_i) begin
                n_cmp++;
                if (bin_in !== W'((base + enables) % (1 << W))) begin
                    n_fail++;
                    $display("FAIL count_end: got %0d expected %0d", bin_in, (base + enables) % (1 << W));
                end
            end
            gray_log.push_back(gray_in);
            wrap_log.push_back(wrap);
            step_edge();
        end
        abort   = 1'b0;
        ref_cnt = (base + enables) % (1 << W);
        n_cmp++;
        if (wraps != wraps_exp) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d expected %0d", wraps, wraps_exp);
        end
        $display("cmd clr=%0d steps=%0d abort_at=%0d keep=%0d -> enables=%0d wraps=%0d end=%0d",
                 clr, n, ab_at, keep, enables, wraps_exp, ref_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        abort = 1'b0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_steps = C'(5);
        cmd_bus.cmd_clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_edge();
            @(negedge clk);
            n_cmp++;
            if ({cmd_bus.cmd_ready, busy, cnt_clr, cnt_en, done, aborted, wrap, err} !== 8'b1000_0000
                || steps_left !== '0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d: got rdy=%b busy=%b clr=%b en=%b done=%b ab=%b wrap=%b err=%b sl=%0d",
                         k, cmd_bus.cmd_ready, busy, cnt_clr, cnt_en, done, aborted, wrap, err, steps_left);
            end
        end
        step_edge();
        cmd_bus.cmd_valid = 1'b0;
        rst = 1'b1;
        step_edge();
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: got busy=%b ready=%b expected 0/1", busy, cmd_bus.cmd_ready);
        end
        step_edge();
        $display("reset: idle after release, command during reset ignored");
    endtask

    task automatic test_clear_run();
        logic [W-1:0] walk [9];
        walk = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        run_cmd(1'b1, 8, 0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (gray_log[k+2] !== walk[k]) begin
                n_fail++;
                $display("FAIL gray_walk t+%0d: got %b expected %b", k + 2, gray_log[k+2], walk[k]);
            end
        end
        for (int k = 1; k <= 10; k++) begin
            n_cmp++;
            if (wrap_log[k] !== (k == 10)) begin
                n_fail++;
                $display("FAIL wrap_cycle t+%0d: got %b expected %b", k, wrap_log[k], (k == 10));
            end
        end
    endtask

    task automatic test_zero_steps();
        run_cmd(1'b0, 0, 0, 1'b0, 1'b0);
        run_cmd(1'b1, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        run_cmd(1'b0, 20, 5, 1'b0, 1'b0);
        run_cmd(1'b1, 6, 0, 1'b0, 1'b1);
        run_cmd(1'b0, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_steps = C'(10);
        cmd_bus.cmd_clear = 1'b0;
        step_edge();
        cmd_bus.cmd_valid = 1'b0;
        step_edge();
        step_edge();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step_edge();
            @(negedge clk);
            n_cmp++;
            if ({cmd_bus.cmd_ready, busy, cnt_en, cnt_clr, done, aborted, wrap, err} !== 8'b1000_0000
                || steps_left !== '0) begin
                n_fail++;
                $display("FAIL reset_midrun k=%0d: got rdy=%b busy=%b en=%b clr=%b done=%b ab=%b wrap=%b err=%b sl=%0d",
                         k, cmd_bus.cmd_ready, busy, cnt_en, cnt_clr, done, aborted, wrap, err, steps_left);
            end
        end
        step_edge();
        rst = 1'b1;
        ref_cnt = (ref_cnt + 3) % (1 << W);
        step_edge();
        $display("reset mid-run: returned to idle without done");
        run_cmd(1'b1, 5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_cmd(1'b0, 3, 0, 1'b1, 1'b0);
        run_cmd(1'b1, 2, 0, 1'b1, 1'b0);
        run_cmd(1'b0, 4, 0, 1'b0, 1'b0);
    endtask

    task automatic test_max_steps();
        run_cmd(1'b0, (1 << C) - 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int n, ab_at;
        logic clr, noise;
        for (int k = 0; k < 20; k++) begin
            clr   = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            n     = $urandom_range(0, 24);
            ab_at = (n > 0 && ($urandom % 3) == 0) ? $urandom_range(1, n) : 0;
            run_cmd(clr, n, ab_at, 1'b0, noise);
            for (int g = 0; g < $urandom_range(0, 2); g++) step_edge();
        end
    endtask

    task automatic test_gray_err();
        run_cmd(1'b1, 1, 0, 1'b0, 1'b0);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_steps = C'(1);
        cmd_bus.cmd_clear = 1'b0;
        step_edge();
        cmd_bus.cmd_valid = 1'b0;
        step_edge();
        force_gray = 1'b1;
        force_val  = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early: got %b expected 0", err);
        end
        step_edge();
        force_gray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (err !== ERR_EXP) begin
                n_fail++;
                $display("FAIL err_sticky k=%0d: got %b expected %b", k, err, ERR_EXP);
            end
            step_edge();
        end
        ref_cnt = (ref_cnt + 1) % (1 << W);
        rst = 1'b0;
        step_edge();
        rst = 1'b1;
        step_edge();
        step_edge();
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_after_reset: got %b expected 0", err);
        end
        step_edge();
        $display("gray error injection: err expected %b until reset", ERR_EXP);
        run_cmd(1'b0, 9, 0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean_run: got %b expected 0", err);
        end
        step_edge();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        abort = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_steps = '0;
        cmd_bus.cmd_clear = 1'b0;
        test_reset();
        test_clear_run();
        test_zero_steps();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        test_max_steps();
        test_random();
        test_gray_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Command-driven sequencer for the `gray_counter` datapath. It accepts "clear and/or advance N steps" commands over a valid/ready handshake and drives the counter's clear and enable strobes for exactly the requested number of cycles. It watches the counter's binary/Gray outputs to flag wrap-around and, optionally, Gray-code integrity errors. It sits between a test/host sequencer and one `gray_counter` instance.

## Interface
- `WIDTH`, 3: counter width; must match the attached `gray_counter`.
- `CNT_W`, 8: width of the step count.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command; high only in IDLE.
- `cmd_steps`  in  CNT_W  number of enable cycles to issue; sampled on accept.
- `cmd_clear`  in  1  issue one clear cycle before stepping; sampled on accept.
- `abort`  in  1  terminate an active run early.
- `cnt_clr`  out  1  clear strobe to the counter.
- `cnt_en`  out  1  count-enable strobe to the counter.
- `bin_in`  in  WIDTH  counter binary output (`o_o`).
- `gray_in`  in  WIDTH  counter Gray output.
- `busy`  out  1  high in CLEAR and RUN.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: the run ended by `abort`.
- `steps_left`  out  CNT_W  remaining enable cycles.
- `wrap`  out  1  one-cycle pulse when the counter wraps from all-ones to 0.
- `err`  out  1  sticky Gray integrity error; tied 0 unless the checker is enabled.

## Operation
- The FSM has four states: IDLE, CLEAR, RUN, DONE.
- Reset values apply while `rst`=0, sampled at a clock edge.
  - State is IDLE.
  - `cmd_ready`=1.
  - `cnt_clr`, `cnt_en`, `busy`, `done`, `aborted`, `wrap`, `err` = 0.
  - `steps_left`=0.
- Commands presented while `rst`=0 are not accepted.
- A command is accepted on a cycle where `cmd_valid`&`cmd_ready`=1. `steps_left` loads `cmd_steps` on that cycle.
- IDLE transitions on accept:
  - `cmd_clear`=1 → CLEAR.
  - `cmd_clear`=0 and `cmd_steps`≠0 → RUN.
  - `cmd_clear`=0 and `cmd_steps`=0 → DONE.
- CLEAR lasts one cycle with `cnt_clr`=1 and `cnt_en`=0. It then goes to RUN if `steps_left`≠0, else DONE.
- RUN:
  - `cnt_en`=1 every cycle.
  - `steps_left` decrements each cycle.
  - Leaves for DONE on the cycle `steps_left` reaches 0, so exactly `cmd_steps` enable cycles are issued.
- `abort`=1 in RUN:
  - `cnt_en` drops that same cycle (combinational gate).
  - The FSM enters DONE next cycle with `aborted`=1.
  - `steps_left` holds its value.
- `abort` in IDLE or CLEAR is ignored.
- DONE lasts one cycle with `done`=1, then the FSM returns to IDLE.
- `cnt_clr` and `cnt_en` are never both high.
- `wrap` fires one cycle after an enable cycle in which the previous `bin_in` was all-ones and the new `bin_in` is 0.
- A `cmd_steps` value of 2^CNT_W−1 is legal; there is no overflow.

## Timing
- With clear: accept at cycle t → CLEAR at t+1 → RUN at t+2 … t+1+N → DONE at t+2+N → `cmd_ready` at t+3+N.
- Without clear: RUN starts at t+1.
- `cmd_ready` is low from t+1 through DONE, so commands cannot be back-to-back. Minimum spacing between accepts is N+3 cycles (clear) or N+2 cycles (no clear, N≥1).
- The counter reflects an enable or clear issued at cycle k on its outputs at cycle k+1. The controller samples `bin_in`/`gray_in` with this one-cycle lag.
- Reset asserted mid-run: at the next edge the FSM goes to IDLE and every output returns to its reset value. No `done` is issued.

## Configuration
- `GRAY_CTRL_CHECK_EN` defined: a Gray checker is compiled in. Each cycle it requires:
  - `gray_in` == `bin_in ^ (bin_in>>1)`.
  - After an enable cycle, `gray_in` differs from its previous sampled value in exactly one bit.
  - After a cycle with neither enable nor clear, `gray_in` is unchanged.
  - After a clear cycle, `gray_in` == 0.
  - Any violation sets `err`=1, which stays high until reset.
- Macro undefined: no checker logic is built and `err` is constant 0.

## Test plan
- Reset, then `cmd_clear`=1, `cmd_steps`=8, WIDTH=3 → `cnt_clr` at t+1; `cnt_en` for exactly 8 cycles; `gray_in` walks 000,001,011,010,110,111,101,100,000; `wrap` pulses once; `done`=1, `aborted`=0 at t+10; `cmd_ready` back at t+11.
- `cmd_clear`=0, `cmd_steps`=0 → no strobes; `done` at t+1; `steps_left`=0.
- `cmd_steps`=20 with `abort` in the 5th RUN cycle → exactly 4 enable cycles; `done`=`aborted`=1; `steps_left`=16.
- `rst`=0 in the 3rd RUN cycle → `cnt_en`=0 and `cmd_ready`=1 after that edge; no `done`; the next command runs normally.
- `cmd_valid` held high through a run → the second command is accepted only once `cmd_ready` returns, in IDLE.
- With `GRAY_CTRL_CHECK_EN`, force `gray_in` to jump 001→010 on an enable cycle → `err` rises one cycle later and stays high until reset. Without the macro, `err` stays 0.
